// File: rtl/alu_sequencer_pkg.sv
// Shared types and widths for the ALU command sequencer.
package alu_sequencer_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned FUNC_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_LATCH,
        ST_WRITE
    } state_t;

    typedef struct packed {
        logic              load;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [FUNC_W-1:0] func;
        logic [DATA_W-1:0] imm;
    } cmd_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command handshake between a command source and the ALU sequencer.
interface alu_sequencer_if;
    import alu_sequencer_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_load;
    logic [REG_W-1:0]  cmd_rd;
    logic [REG_W-1:0]  cmd_rs;
    logic [REG_W-1:0]  cmd_rt;
    logic [FUNC_W-1:0] cmd_func;
    logic [DATA_W-1:0] cmd_imm;

    modport master (
        output cmd_valid, cmd_load, cmd_rd, cmd_rs, cmd_rt, cmd_func, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_rd, cmd_rs, cmd_rt, cmd_func, cmd_imm,
        output cmd_ready
    );

endinterface

// File: rtl/alu_sequencer.sv
// Sequences one load or ALU command at a time onto a register-bank datapath.
// Every datapath output is registered and set on the edge that enters its state.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    alu_sequencer_if.slave    cmd,
    output logic [REG_W-1:0]  reg1Addr,
    output logic [REG_W-1:0]  reg2Addr,
    output logic [REG_W-1:0]  regWrite,
    output logic [FUNC_W-1:0] aluControl,
    output logic [DATA_W-1:0] regWriteData,
    output logic              write,
    output logic              write_to_reg,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  done_count
);

    state_t state;
    cmd_t   cmd_q;
    logic   ready_q;

    assign cmd.cmd_ready = ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cmd_q        <= '0;
            ready_q      <= 1'b1;
            busy         <= 1'b0;
            reg1Addr     <= '0;
            reg2Addr     <= '0;
            regWrite     <= '0;
            aluControl   <= '0;
            regWriteData <= '0;
            write        <= 1'b0;
            write_to_reg <= 1'b0;
            done         <= 1'b0;
            done_count   <= '0;
        end else begin
            done         <= 1'b0;
            write_to_reg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        cmd_q.load <= cmd.cmd_load;
                        cmd_q.rd   <= cmd.cmd_rd;
                        cmd_q.rs   <= cmd.cmd_rs;
                        cmd_q.rt   <= cmd.cmd_rt;
                        cmd_q.func <= cmd.cmd_func;
                        cmd_q.imm  <= cmd.cmd_imm;
                        ready_q    <= 1'b0;
                        busy       <= 1'b1;
                        // Loads skip the operand-read phases entirely
                        if (cmd.cmd_load) begin
                            state        <= ST_LATCH;
                            write        <= 1'b1;
                            regWriteData <= cmd.cmd_imm;
                        end else begin
                            state      <= ST_READ;
                            reg1Addr   <= cmd.cmd_rs;
                            reg2Addr   <= cmd.cmd_rt;
                            aluControl <= cmd.cmd_func;
                        end
                    end
                end
                ST_READ, ST_EXEC: begin
                    state      <= (state == ST_READ) ? ST_EXEC : ST_LATCH;
                    reg1Addr   <= cmd_q.rs;
                    reg2Addr   <= cmd_q.rt;
                    aluControl <= cmd_q.func;
                end
                ST_LATCH: begin
                    state        <= ST_WRITE;
                    write        <= cmd_q.load;
                    regWriteData <= cmd_q.load ? cmd_q.imm : '0;
                    regWrite     <= cmd_q.rd;
                    // Register 0 is hardwired; the command still retires
                    write_to_reg <= (cmd_q.rd != '0);
                    done         <= 1'b1;
                    done_count   <= done_count + CNT_W'(1);
                end
                ST_WRITE: begin
                    state        <= ST_IDLE;
                    ready_q      <= 1'b1;
                    busy         <= 1'b0;
                    reg1Addr     <= '0;
                    reg2Addr     <= '0;
                    regWrite     <= '0;
                    aluControl   <= '0;
                    regWriteData <= '0;
                    write        <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
